// File: rtl/arbiter3_requester_if.sv
// Job-side and arbiter-side signal bundle for arbiter3_requester.
// master = the requester agent, slave = job sources plus arbiter.
interface arbiter3_requester_if #(
    parameter int LEN_W = 4
);
    logic [2:0]         job_valid;
    logic [2:0]         job_ready;
    logic [3*LEN_W-1:0] job_len;
    logic [2:0]         req;
    logic [2:0]         grant;
    logic [2:0]         done;
    logic [2:0]         timeout;
    logic               err_spurious;
    logic               err_multi;

    modport master (
        input  job_valid, job_len, grant,
        output job_ready, req, done, timeout, err_spurious, err_multi
    );

    modport slave (
        output job_valid, job_len, grant,
        input  job_ready, req, done, timeout, err_spurious, err_multi
    );
endinterface

// File: rtl/arbiter3_requester.sv
// Three-channel requester for a 3-way round-robin arbiter, with a grant-legality monitor.
// Optional request-wait timeout: define ARB_REQ_TIMEOUT_EN.

module arbiter3_requester_ch #(
    parameter int LEN_W          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    input  logic [LEN_W-1:0] job_len,
    input  logic             grant,
    output logic             job_ready,
    output logic             req,
    output logic             done,
    output logic             timeout
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY} state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             req_q, req_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;

`ifdef ARB_REQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);
    logic [WAIT_W-1:0] wait_q, wait_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
`ifdef ARB_REQ_TIMEOUT_EN
        wait_d    = wait_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (job_valid) begin
                    cnt_d   = job_len;
                    state_d = S_REQ;
`ifdef ARB_REQ_TIMEOUT_EN
                    wait_d  = '0;
`endif
                end
            end
            S_REQ: begin
                // The granting edge is itself a burst cycle; a grant on the
                // timeout edge takes priority over abandoning the job.
                if (grant) begin
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_q - 1'b1;
                        state_d = S_BUSY;
                    end
                end
`ifdef ARB_REQ_TIMEOUT_EN
                else if (wait_q + 1'b1 == WAIT_MAX) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            S_BUSY: begin
                if (grant) begin
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end else begin
                    // Preempted: keep the remaining count and request again.
                    state_d = S_REQ;
`ifdef ARB_REQ_TIMEOUT_EN
                    wait_d  = '0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
        req_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            req_q     <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            req_q     <= req_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef ARB_REQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wait_q <= '0;
        else     wait_q <= wait_d;
    end
`endif

    assign job_ready = ready_q;
    assign req       = req_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
endmodule

module arbiter3_requester #(
    parameter int LEN_W          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    arbiter3_requester_if.master bus
);
    logic [2:0] ready_w, req_w, done_w, timeout_w;
    logic       err_spurious_q, err_spurious_d;
    logic       err_multi_q, err_multi_d;

    for (genvar n = 0; n < 3; n++) begin : g_ch
        arbiter3_requester_ch #(
            .LEN_W          (LEN_W),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .job_valid (bus.job_valid[n]),
            .job_len   (bus.job_len[n*LEN_W +: LEN_W]),
            .grant     (bus.grant[n]),
            .job_ready (ready_w[n]),
            .req       (req_w[n]),
            .done      (done_w[n]),
            .timeout   (timeout_w[n])
        );
    end

    // Judged against the registered req the arbiter actually sees.
    always_comb begin
        err_spurious_d = err_spurious_q | (|(bus.grant & ~req_w));
        err_multi_d    = err_multi_q | (|(bus.grant & (bus.grant - 3'd1)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_spurious_q <= 1'b0;
            err_multi_q    <= 1'b0;
        end else begin
            err_spurious_q <= err_spurious_d;
            err_multi_q    <= err_multi_d;
        end
    end

    assign bus.job_ready    = ready_w;
    assign bus.req          = req_w;
    assign bus.done         = done_w;
    assign bus.timeout      = timeout_w;
    assign bus.err_spurious = err_spurious_q;
    assign bus.err_multi    = err_multi_q;
endmodule
